mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit output channel among N valid/ready requesters by driving the select of the library's `Mux`. Grants are packet-locked: a granted requester keeps the channel until it transfers a beat with `last` set. The block sits between N stream producers and a single downstream consumer. It is the sequencing layer above the pure combinational `Mux`.

---
 rtl/mux_arb_pkg.sv | 30 +++
 rtl/mux_rr_arbiter_mux.sv | 19 +
 rtl/mux_rr_arbiter.sv | 100 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick helper for mux_rr_arbiter.
// rr_pick works on a fixed-width valid vector so that any N up to RR_MAX_N can use it.
package mux_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int unsigned RR_MAX_N = 32;

  // Returns the first asserted index scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  // If nothing is asserted, ptr is returned unchanged.
  function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] valid,
                                          input int unsigned         ptr,
                                          input int unsigned         n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Pure combinational N:1 multiplexer; the arbiter uses it to steer {last, data}.
module Mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [WIDTH-1:0] i_d [N-1:0],
  input  logic [SW-1:0]    i_sel,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    for (int i = 0; i < N; i++) begin
      if (i_sel == SW'(i)) o_y = i_d[i];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one valid/ready channel among N requesters.
// Selection is purely from registered state/sel; only the owner's req_* reach the outputs.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [WIDTH-1:0] req_data [N-1:0],
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [N-1:0]     grant,
  output logic [SW-1:0]    sel,
  output logic             busy
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [SW-1:0]       r_sel;
  logic [SW-1:0]       w_sel_nxt;
  logic [SW-1:0]       r_ptr;
  logic [SW-1:0]       w_ptr_nxt;
  logic [RR_MAX_N-1:0] w_valid_ext;
  logic [WIDTH:0]      w_mux_in [N-1:0];
  logic [WIDTH:0]      w_mux_y;
  logic                w_busy;
  logic                w_hs;

  always_comb begin
    for (int i = 0; i < N; i++) w_mux_in[i] = {req_last[i], req_data[i]};
  end

  Mux #(WIDTH + 1, N) u_mux (
    .i_d   (w_mux_in),
    .i_sel (r_sel),
    .o_y   (w_mux_y)
  );

  assign w_valid_ext = RR_MAX_N'(req_valid);
  assign w_busy      = (r_state == ARB_BUSY);
  assign w_hs        = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|req_valid) begin
          w_sel_nxt   = SW'(rr_pick(w_valid_ext, 32'(r_ptr), N));
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (w_hs && w_mux_y[WIDTH]) begin
          w_state_nxt = ARB_IDLE;
          // Explicit wrap so non-power-of-two N returns to 0, not to N.
          w_ptr_nxt   = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      grant[i]     = w_busy && (r_sel == SW'(i));
      req_ready[i] = w_busy && (r_sel == SW'(i)) && out_ready;
    end
  end

  assign out_valid = w_busy && req_valid[r_sel];
  assign out_data  = w_mux_y[WIDTH-1:0];
  assign out_last  = w_mux_y[WIDTH];
  assign sel       = r_sel;
  assign busy      = w_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (owner, pointer, per-requester packet counters).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [7:0] req_data [3:0];
  logic [3:0] req_last = '0;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  logic       rst3 = 1'b1;
  logic [2:0] req_valid3 = '0;
  logic [7:0] req_data3 [2:0];
  logic [2:0] req_last3 = '0;
  logic [2:0] req_ready3;
  logic       out_valid3;
  logic [7:0] out_data3;
  logic       out_last3;
  logic       out_ready3 = 1'b0;
  logic [2:0] grant3;
  logic [1:0] sel3;
  logic       busy3;

  int n_cmp = 0;
  int n_mis = 0;

  int m_busy, m_owner, m_ptr;
  int p_rem [4];
  int p_seq [4];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant(grant), .sel(sel), .busy(busy)
  );

  mux_rr_arbiter #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_data(req_data3),
    .req_last(req_last3), .req_ready(req_ready3), .out_valid(out_valid3),
    .out_data(out_data3), .out_last(out_last3), .out_ready(out_ready3),
    .grant(grant3), .sel(sel3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_all(input logic [3:0] v, input logic [3:0] l, input logic [7:0] d);
    req_valid = v;
    req_last  = l;
    for (int i = 0; i < 4; i++) req_data[i] = d + 8'(i);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i] = '0;
    for (int i = 0; i < 3; i++) req_data3[i] = '0;

    // Reset state and a single 3-beat request on requester 2.
    #12 rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = 4'b0100; req_data[2] = 8'h11; req_last = 4'b0000;
    #1;
    chk("single_pre_grant", 32'(grant), 32'h0);
    chk("single_pre_ovalid", 32'(out_valid), 32'h0);
    @(negedge clk); #1;
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_d0", 32'(out_data), 32'h11);
    chk("single_ready", 32'(req_ready), 32'h4);
    @(negedge clk); req_data[2] = 8'h12; #1;
    chk("single_d1", 32'(out_data), 32'h12);
    @(negedge clk); req_data[2] = 8'h13; req_last = 4'b0100; #1;
    chk("single_d2", 32'(out_data), 32'h13);
    chk("single_last", 32'(out_last), 32'h1);
    @(negedge clk); req_valid = '0; req_last = '0; #1;
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_sel", 32'(sel), 32'h2);

    // Fairness with 1-beat packets: starting pointer is 3 after the release above.
    @(negedge clk); drive_all(4'b1111, 4'b1111, 8'h40); #1;
    chk("rr_first_idle", 32'(grant), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) req_valid = '0;
      #1;
      if (k % 2 == 0) begin
        chk("rr_grant", 32'(grant), 32'(4'b0001 << ((3 + k / 2) % 4)));
        chk("rr_data", 32'(out_data), 32'(8'h40 + 8'((3 + k / 2) % 4)));
      end else begin
        chk("rr_bubble", 32'(grant), 32'h0);
      end
    end

    // Randomized run against the transaction-level model.
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) begin p_rem[i] = 0; p_seq[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (p_rem[i] == 0) p_rem[i] = int'($urandom_range(1, 4));
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_data[i]  = {2'(i), 6'(p_seq[i])};
        req_last[i]  = (p_rem[i] == 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_sel", 32'(sel), 32'(m_owner));
      chk("m_grant", 32'(grant), m_busy ? 32'(1 << m_owner) : 32'h0);
      chk("m_ready", 32'(req_ready), (m_busy && out_ready) ? 32'(1 << m_owner) : 32'h0);
      chk("m_ovalid", 32'(out_valid), m_busy ? 32'(req_valid[m_owner]) : 32'h0);
      if (m_busy != 0) begin
        chk("m_data", 32'(out_data), 32'({2'(m_owner), 6'(p_seq[m_owner])}));
        chk("m_last", 32'(out_last), 32'(p_rem[m_owner] == 1));
      end
      @(posedge clk);
      if (m_busy != 0) begin
        if (req_valid[m_owner] && out_ready) begin
          p_seq[m_owner]++;
          p_rem[m_owner]--;
          if (p_rem[m_owner] == 0) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 4;
          end
        end
      end else if (req_valid != 0) begin
        for (int k = 3; k >= 0; k--) begin
          if (req_valid[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        m_busy = 1;
      end
    end

    // Asynchronous reset on beat 2 of a 4-beat packet from requester 1.
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0;
    out_ready = 1'b1;
    drive_all(4'b0010, 4'b0000, 8'h20);
    @(negedge clk); #1;
    chk("mid_grant", 32'(grant), 32'h2);
    @(negedge clk); #1;
    chk("mid_beat2_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ovalid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_all(4'b1110, 4'b1111, 8'h50);
    req_valid[0] = 1'b1;
    @(negedge clk); #1;
    chk("mid_restart", 32'(grant), 32'h1);

    // N = 3 wrap: owner 2 releases, next pick starts from 0.
    rst3 = 1'b0;
    out_ready3 = 1'b1;
    req_valid3 = 3'b100; req_last3 = 3'b100; req_data3[2] = 8'h72;
    @(negedge clk); #1;
    chk("n3_grant2", 32'(grant3), 32'h4);
    chk("n3_data2", 32'(out_data3), 32'h72);
    @(negedge clk);
    req_valid3 = 3'b011; req_last3 = 3'b011;
    req_data3[0] = 8'h70; req_data3[1] = 8'h71;
    #1;
    chk("n3_bubble", 32'(grant3), 32'h0);
    @(negedge clk); #1;
    chk("n3_wrap_grant", 32'(grant3), 32'h1);
    chk("n3_wrap_sel", 32'(sel3), 32'h0);
    chk("n3_wrap_data", 32'(out_data3), 32'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
